// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter
//   Shares one combinational IEEE-754 single-precision divider between NREQ
//   requesters. Round-robin grant in IDLE. The granted operands are registered
//   and held on the divider for WAIT_CYC cycles as a multicycle path. The
//   quotient is then captured and presented until the granted requester takes it.
// Ports
//   clk, rst    clock and asynchronous active-high reset
//   req_valid   per-requester operand pair pending
//   req_ready   one-hot accept, only in IDLE
//   req_a/req_b packed 32-bit dividend/divisor, requester i at [32*i+31:32*i]
//   rsp_valid   one-hot result presentation, only in RESP
//   rsp_ready   per-requester result taken
//   rsp_data    registered quotient
//   busy        high whenever not in IDLE

module fp32_div (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out
);
  // Subnormal operands are pre-normalised, so both significands reach the
  // quotient stage with their MSB set.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [23:0] t;
    logic [4:0]  n;
    t = v;
    n = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (!t[23]) begin
        t = t << 1;
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic               sq, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [4:0]         lza, lzb;
  logic [23:0]        na, nb;
  logic signed [10:0] xa, xb, er, sh;
  logic [49:0]        dividend, divisor, rem;
  logic [26:0]        quot, q27;
  logic               sticky, up;
  logic [22:0]        m;
  logic [30:0]        packed_res;

  // The quotient keeps 24 significand bits plus three guard bits; the
  // remainder supplies the sticky bit for round-to-nearest-even.
  always_comb begin
    sq     = in1[31] ^ in2[31];
    a_nan  = (in1[30:23] == 8'hFF) && (in1[22:0] != 23'd0);
    b_nan  = (in2[30:23] == 8'hFF) && (in2[22:0] != 23'd0);
    a_inf  = (in1[30:23] == 8'hFF) && (in1[22:0] == 23'd0);
    b_inf  = (in2[30:23] == 8'hFF) && (in2[22:0] == 23'd0);
    a_zero = (in1[30:0] == 31'd0);
    b_zero = (in2[30:0] == 31'd0);

    lza = lzc24({1'b0, in1[22:0]});
    lzb = lzc24({1'b0, in2[22:0]});
    if (in1[30:23] != 8'd0) begin
      na = {1'b1, in1[22:0]};
      xa = 11'($unsigned(in1[30:23]));
    end else begin
      na = {1'b0, in1[22:0]} << lza;
      xa = 11'sd1 - $signed({6'b0, lza});
    end
    if (in2[30:23] != 8'd0) begin
      nb = {1'b1, in2[22:0]};
      xb = 11'($unsigned(in2[30:23]));
    end else begin
      nb = {1'b0, in2[22:0]} << lzb;
      xb = 11'sd1 - $signed({6'b0, lzb});
    end

    // A zero divisor is replaced so the integer divide stays defined; the
    // special-case mux below decides the result in that case.
    dividend = {na, 26'd0};
    divisor  = b_zero ? 50'h800000 : {26'd0, nb};
    quot     = 27'(dividend / divisor);
    rem      = dividend % divisor;
    sticky   = (rem != 50'd0);

    if (quot[26]) begin
      q27 = quot;
      er  = xa - xb + 11'sd127;
    end else begin
      q27 = {quot[25:0], 1'b0};
      er  = xa - xb + 11'sd126;
    end

    // Results below the normal range are denormalised with sticky collection.
    sh = 11'sd0;
    if (er <= 11'sd0) begin
      sh = 11'sd1 - er;
      if (sh > 11'sd26) begin
        sticky = sticky | (|q27);
        q27    = 27'd0;
      end else begin
        sticky = sticky | (|(q27 & ((27'd1 << sh) - 27'd1)));
        q27    = q27 >> sh;
      end
      er = 11'sd0;
    end

    m  = q27[25:3];
    up = q27[2] & ((|q27[1:0]) | sticky | m[0]);
    // The rounding carry may ripple into the exponent: subnormal to normal,
    // or largest normal to infinity; both encode correctly.
    packed_res = {er[7:0], m} + 31'(up);

    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      out = 32'h7FC00000;
    else if (a_inf || b_zero)
      out = {sq, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      out = {sq, 31'd0};
    else if (er >= 11'sd255)
      out = {sq, 8'hFF, 23'd0};
    else
      out = {sq, packed_res};
  end
endmodule

module fp_div_arbiter #(
  parameter int NREQ     = 2,
  parameter int WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 busy
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(WAIT_CYC + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] last_grant, gnt, sel;
  logic [GW:0]   rr_sum;
  logic          sel_found;
  logic [31:0]   op_a, op_b, div_out;
  logic [CW-1:0] counter;
  logic [31:0]   a_arr [NREQ];
  logic [31:0]   b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    rr_sum    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = {1'b0, last_grant} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(NREQ))
        rr_sum = rr_sum - (GW+1)'(NREQ);
      if (!sel_found && req_valid[rr_sum[GW-1:0]]) begin
        sel       = rr_sum[GW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  // Reset gates req_ready so nothing looks accepted while reset is held.
  assign req_ready = (state == IDLE && sel_found && !rst) ? (NREQ'(1) << sel) : '0;
  assign rsp_valid = (state == RESP) ? (NREQ'(1) << gnt) : '0;
  assign busy      = (state != IDLE);

  fp32_div u_div (
    .in1 (op_a),
    .in2 (op_b),
    .out (div_out)
  );

  // Accept, hold operands for WAIT_CYC cycles, capture, then wait for handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ - 1);
      gnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_data   <= '0;
      counter    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            op_a    <= a_arr[sel];
            op_b    <= b_arr[sel];
            gnt     <= sel;
            counter <= CW'(WAIT_CYC - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (counter == '0) begin
            rsp_data <= div_out;
            state    <= RESP;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            last_grant <= gnt;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter
//   Drives two arbiter instances: a 2-requester, 2-cycle one and a
//   3-requester, 1-cycle one. Expected quotients come from real-valued
//   division rounded back to single precision; expected grants come from a
//   plain round-robin rule.

module tb_fp_div_arbiter;
  localparam int W_A = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_data;
  logic        busy;

  logic [2:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [95:0] b_req_a, b_req_b;
  logic [31:0] b_rsp_data;
  logic        b_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int last_gnt;
  int b_last;
  logic [31:0] b_exp [3];

  always #5 clk = ~clk;

  fp_div_arbiter #(.NREQ(2), .WAIT_CYC(W_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  fp_div_arbiter #(.NREQ(3), .WAIT_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .busy(b_busy)
  );

  // Single-precision (normal or zero) widened exactly to double.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Double rounded to nearest-even single precision (normal range only).
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [28:0] rest;
    logic [22:0] frac;
    int          e;
    logic        up;
    d    = $realtobits(r);
    e    = int'(d[62:52]) - 1023 + 127;
    frac = d[51:29];
    rest = d[28:0];
    up   = (rest > 29'h10000000) || ((rest == 29'h10000000) && frac[0]);
    return {d[63], 8'(e), frac} + 32'(up);
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) / f2r(b));
  endfunction

  function automatic logic [31:0] rand_operand();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  function automatic int next_grant(input int last, input logic [2:0] valid, input int n);
    for (int k = 1; k <= n; k++) begin
      if (valid[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  // One full operation on dut_a: grant, latency, result, optional backpressure.
  task automatic runOp(input int hold, output int g, output logic [31:0] res);
    int          lat;
    logic [31:0] exp;
    #1;
    g = next_grant(last_gnt, {1'b0, req_valid}, 2);
    checkOutput("grant_ready", 32'(req_ready), 32'(1) << g);
    exp = ref_div(req_a[32*g +: 32], req_b[32*g +: 32]);
    tick();
    req_a[32*g +: 32] = rand_operand();
    req_b[32*g +: 32] = rand_operand();
    checkOutput("busy_wait", 32'(busy), 32'd1);
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(W_A + 1));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << g);
    checkOutput("rsp_data", rsp_data, exp);
    res = rsp_data;
    rsp_ready = ~(2'(1) << g);
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput("hold_valid", 32'(rsp_valid), 32'(1) << g);
      checkOutput("hold_data", rsp_data, exp);
      checkOutput("hold_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 2'b11;
    tick();
    last_gnt = g;
    checkOutput("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          g, pg;
    logic [31:0] res;
    logic [31:0] exp;

    // Reset held for 3 cycles with every request asserted.
    rst = 1'b1;
    req_a = '0; req_b = '0; b_req_a = '0; b_req_b = '0;
    applyStimulus(2'b11, 2'b11);
    b_req_valid = 3'b111;
    b_rsp_ready = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rsp_data", rsp_data, 32'd0);
      checkOutput("rst_b_ready", 32'(b_req_ready), 32'd0);
    end
    b_req_valid = 3'b000;
    applyStimulus(2'b01, 2'b11);
    req_a[31:0] = 32'h3FC00000;
    req_b[31:0] = 32'h40300000;
    rst = 1'b0;
    last_gnt = 1;
    b_last = 2;
    $display("[TB] single request from requester 0");
    runOp(0, g, res);
    checkOutput("t2_const", res, 32'h3F0BA2E9);

    // A request dropped before any clock edge is never accepted.
    applyStimulus(2'b01, 2'b11);
    #1;
    checkOutput("withdraw_ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    tick();
    checkOutput("withdraw_busy", 32'(busy), 32'd0);

    // Both requesting after reset: requester 0 first, then strict alternation.
    rst = 1'b1;
    tick();
    tick();
    req_a[31:0] = 32'hC0600000;
    req_b[31:0] = 32'hBFA00000;
    req_a[63:32] = rand_operand();
    req_b[63:32] = rand_operand();
    applyStimulus(2'b11, 2'b11);
    rst = 1'b0;
    last_gnt = 1;
    $display("[TB] two requesters, round robin");
    runOp(0, g, res);
    checkOutput("t3_const", res, 32'h40333333);
    pg = g;
    for (int k = 0; k < 5; k++) begin
      runOp(0, g, res);
      checkOutput("t3_alternate", 32'(g), 32'(1 - pg));
      pg = g;
    end

    // Backpressure for 5 cycles with the other requester waiting.
    $display("[TB] response backpressure");
    applyStimulus(2'b11, 2'b11);
    runOp(5, g, res);

    // Reset during WAIT after requester 1 was accepted, with last grant at 0.
    $display("[TB] reset during wait");
    applyStimulus(2'b01, 2'b11);
    runOp(0, g, res);
    req_valid = 2'b10;
    #1;
    checkOutput("t5_ready1", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    last_gnt = 1;
    runOp(0, g, res);

    // Three requesters, single-cycle hold: one accept every three cycles.
    $display("[TB] three requesters, one wait cycle");
    b_req_a[31:0]  = 32'h3F800000; b_req_b[31:0]  = 32'h00000000; b_exp[0] = 32'h7F800000;
    b_req_a[63:32] = 32'h00000000; b_req_b[63:32] = 32'h00000000; b_exp[1] = 32'h7FC00000;
    b_req_a[95:64] = 32'h00800000; b_req_b[95:64] = 32'h40000000; b_exp[2] = 32'h00400000;
    b_req_valid = 3'b111;
    b_rsp_ready = 3'b111;
    #1;
    for (int k = 0; k < 12; k++) begin
      g = k % 3;
      checkOutput("t6_ready", 32'(b_req_ready), 32'(1) << g);
      exp = b_exp[g];
      tick();
      if (k == 0) begin
        b_req_a[31:0] = 32'h00800001;
        b_req_b[31:0] = 32'h40000000;
        b_exp[0]      = 32'h00400000;
      end else begin
        b_req_a[32*g +: 32] = rand_operand();
        b_req_b[32*g +: 32] = rand_operand();
        b_exp[g] = ref_div(b_req_a[32*g +: 32], b_req_b[32*g +: 32]);
      end
      checkOutput("t6_wait_valid", 32'(b_rsp_valid), 32'd0);
      checkOutput("t6_busy", 32'(b_busy), 32'd1);
      tick();
      checkOutput("t6_rsp_valid", 32'(b_rsp_valid), 32'(1) << g);
      checkOutput("t6_rsp_data", b_rsp_data, exp);
      tick();
      b_last = g;
    end
    b_req_valid = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
